// File: rtl/wave_sample_conditioner.sv
// wave_sample_conditioner
// Conditions 12-bit offset-binary microphone samples into an 8-bit waveform
// sample plus a 4-bit volume bar index. Three modes:
//   raw     - every accepted sample is passed through (top 8 bits)
//   peak    - largest |sample - 2048| over a window of N accepted samples
//   average - mean of the top 8 bits over N samples
// Optional feature macro: WAVE_AVG_EN builds the average-mode accumulator.
// Without it, mode 2'b10 behaves exactly like raw mode.
module wave_sample_conditioner (
  input  logic        clk_sample,
  input  logic        rst_n,
  input  logic [11:0] mic_in,
  input  logic        mic_valid,
  input  logic [1:0]  mode,
  input  logic [1:0]  win_sel,
  input  logic        hold,
  output logic [7:0]  wave_sample,
  output logic        sample_valid,
  output logic [3:0]  peak_level
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t      state_reg;
  logic [1:0]  mode_reg;     // registered copy used to spot mode changes
  logic [1:0]  win_reg;      // registered copy used to spot window changes
  logic [7:0]  count_reg;    // index of the next sample within the window
  logic [10:0] max_reg;      // running peak magnitude of the open window

  logic [7:0]  last_count;
  logic [11:0] below_mid;
  logic [10:0] mag;
  logic [10:0] max_next;
  logic [7:0]  raw_abs;
  logic        window_done;
  logic        config_change;
  logic        is_peak;
  logic        is_avg;

`ifdef WAVE_AVG_EN
  logic [15:0] sum_reg;      // worst case 256 * 255 = 65280 fits in 16 bits
  logic [15:0] sum_next;
  logic [7:0]  avg_out;
`endif

  // Window length decode: the counter closes the window when it reaches N-1.
  always_comb begin
    case (win_reg)
      2'b00:   last_count = 8'd3;
      2'b01:   last_count = 8'd15;
      2'b10:   last_count = 8'd63;
      default: last_count = 8'd255;
    endcase
  end

  // Magnitude around the 2048 mid-scale point; only mic_in = 0 gives 2048,
  // which is clamped to 2047 so the result fits in 11 bits.
  always_comb begin
    below_mid = 12'd2048 - mic_in;
    if (mic_in[11]) begin
      mag = mic_in[10:0];
    end else if (below_mid[11]) begin
      mag = 11'h7FF;
    end else begin
      mag = below_mid[10:0];
    end
    max_next = (mag > max_reg) ? mag : max_reg;
  end

  // Raw-mode volume: distance of the 8-bit sample from 128.
  always_comb begin
    if (mic_in[11]) begin
      raw_abs = {1'b0, mic_in[10:4]};
    end else begin
      raw_abs = 8'd128 - mic_in[11:4];
    end
  end

  // Mode decode and window bookkeeping.
  always_comb begin
    window_done   = (count_reg == last_count);
    config_change = (mode != mode_reg) || (win_sel != win_reg);
    is_peak       = (mode == 2'b01);
`ifdef WAVE_AVG_EN
    is_avg        = (mode == 2'b10);
`else
    is_avg        = 1'b0;
`endif
  end

`ifdef WAVE_AVG_EN
  // Average = sum >> log2(N), including the sample closing the window.
  always_comb begin
    sum_next = sum_reg + {8'd0, mic_in[11:4]};
    case (win_reg)
      2'b00:   avg_out = sum_next[9:2];
      2'b01:   avg_out = sum_next[11:4];
      2'b10:   avg_out = sum_next[13:6];
      default: avg_out = sum_next[15:8];
    endcase
  end
`endif

  // Control FSM with registered outputs. Priority: hold, leaving HOLD,
  // configuration change (drops the partial window and this cycle's sample),
  // then normal sample acceptance.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mode_reg     <= 2'b00;
      win_reg      <= 2'b00;
      count_reg    <= 8'd0;
      max_reg      <= 11'd0;
`ifdef WAVE_AVG_EN
      sum_reg      <= 16'd0;
`endif
      wave_sample  <= 8'h80;
      sample_valid <= 1'b0;
      peak_level   <= 4'd0;
    end else begin
      sample_valid <= 1'b0;
      if (hold) begin
        state_reg <= HOLD;
        mode_reg  <= mode;
        win_reg   <= win_sel;
        count_reg <= 8'd0;
        max_reg   <= 11'd0;
`ifdef WAVE_AVG_EN
        sum_reg   <= 16'd0;
`endif
      end else if (state_reg == HOLD) begin
        state_reg <= IDLE;
        mode_reg  <= mode;
        win_reg   <= win_sel;
      end else if (config_change) begin
        state_reg <= IDLE;
        mode_reg  <= mode;
        win_reg   <= win_sel;
        count_reg <= 8'd0;
        max_reg   <= 11'd0;
`ifdef WAVE_AVG_EN
        sum_reg   <= 16'd0;
`endif
      end else if (mic_valid) begin
        state_reg <= ACCUM;
        if (is_peak) begin
          if (window_done) begin
            wave_sample  <= max_next[10:3];
            peak_level   <= max_next[10:7];
            sample_valid <= 1'b1;
            count_reg    <= 8'd0;
            max_reg      <= 11'd0;
          end else begin
            count_reg    <= count_reg + 8'd1;
            max_reg      <= max_next;
          end
`ifdef WAVE_AVG_EN
        end else if (is_avg) begin
          if (window_done) begin
            wave_sample  <= avg_out;
            peak_level   <= avg_out[7:4];
            sample_valid <= 1'b1;
            count_reg    <= 8'd0;
            sum_reg      <= 16'd0;
          end else begin
            count_reg    <= count_reg + 8'd1;
            sum_reg      <= sum_next;
          end
`endif
        end else begin
          wave_sample  <= mic_in[11:4];
          peak_level   <= raw_abs[6:3];
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/wave_sample_conditioner.md
WAVE_SAMPLE_CONDITIONER -- requirements
Module: wave_sample_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_sample  in  1  sampling clock (20 kHz domain); all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 mic_in  in  12  unsigned offset-binary microphone sample; silence = 2048.
REQ-005 mic_valid  in  1  qualifies mic_in; a sample is accepted on each rising edge with mic_valid=1.
REQ-006 mode  in  2  00 raw, 01 peak, 10 average (macro-gated), 11 treated as raw.
REQ-007 win_sel  in  2  window length N: 00=4, 01=16, 10=64, 11=256 accepted samples.
REQ-008 hold  in  1  freezes outputs while high.
REQ-009 wave_sample  out  8  conditioned sample for the waveform drawer and recorder.
REQ-010 sample_valid  out  1  one-cycle strobe; high in the cycle wave_sample takes a new value.
REQ-011 peak_level  out  4  volume bar index for LEDs/VGA.

Function
REQ-012 States SHALL be IDLE, ACCUM, HOLD; the reset state SHALL be IDLE.
REQ-013 IDLE -> ACCUM on first accepted sample, which is counted as window sample 1.
REQ-014 Any state -> HOLD when hold=1 (priority over all other transitions); HOLD -> IDLE when hold=0.
REQ-015 In HOLD, wave_sample and peak_level SHALL keep their values, sample_valid SHALL stay 0, and the window counter and accumulators SHALL be cleared.
REQ-016 Raw mode: wave_sample = mic_in[11:4], registered, with sample_valid=1 in the cycle after acceptance (latency 1); no windowing.
REQ-017 Peak mode: per accepted sample, mag = |mic_in - 2048| clamped to 2047; running max kept over the window.
REQ-018 Peak mode: on the Nth accepted sample, wave_sample = max[10:3] (including that sample), sample_valid=1 one cycle later; max and counter cleared in the same cycle.
REQ-019 Window counter SHALL be 8 bits and wrap from N-1 to 0; N=256 uses the full 0..255 range with no overflow.
REQ-020 A sample accepted in the same cycle a window closes SHALL belong to the closing window; the next window starts with the following accepted sample.
REQ-021 A change of mode or win_sel (detected against a registered copy) SHALL discard the partial window and return to IDLE without a sample_valid; the sample arriving that cycle SHALL be dropped.
REQ-022 peak_level SHALL equal wave_sample[7:4] in peak and average modes and |mic_in[11:4] - 128|[6:3] in raw mode, updated together with sample_valid.
REQ-023 Cycles with mic_valid=0 SHALL not advance counters or accumulators.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force wave_sample=8'h80, sample_valid=0, peak_level=0, state IDLE, counters/accumulators/registered mode copies to 0.
REQ-025 Reset mid-window SHALL discard the partial window; no sample_valid SHALL occur until a full window (or one raw sample) is accepted after release.

Configuration
REQ-026 Macro WAVE_AVG_EN SHALL gate average mode.
REQ-027 With WAVE_AVG_EN defined: mode 10 sums mic_in[11:4] in a 16-bit accumulator over N samples and outputs sum >> log2(N), timing as REQ-018.
REQ-028 Without WAVE_AVG_EN: no accumulator is built and mode 10 behaves exactly as raw mode.

Verification
REQ-029 Raw: mode=00, mic_in=12'hA50 valid one cycle -> next cycle wave_sample=8'hA5, sample_valid=1 for exactly one cycle, peak_level=4'h4.
REQ-030 Peak: mode=01, win_sel=00, samples 2048, 3072, 1024, 2100 -> one cycle after 4th, wave_sample=8'h80, peak_level=4'h8, single sample_valid.
REQ-031 Peak clamp/wrap: win_sel=11, 256 samples of 12'h000 -> wave_sample=8'hFF after 256th; next 256 samples of 2048 -> wave_sample=8'h00; exactly two sample_valid pulses.
REQ-032 Hold: mid-window assert hold for 10 cycles with valid samples -> outputs unchanged, no strobe; after release a fresh 4-sample window is required before next strobe.
REQ-033 Mode change: after 2 peak samples switch win_sel 00->01 -> no strobe until 16 further accepted samples.
REQ-034 Average (WAVE_AVG_EN): mode=10, win_sel=00, mic_in[11:4]=10,20,30,40 -> wave_sample=8'd25; without macro the same stimulus yields raw output per sample.
